piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out serializer that accepts a DATA_WIDTH-bit word over a valid/ready handshake and emits it one bit at a time with a per-bit shift strobe. It sits directly upstream of the team's serial-in parallel-out shift register: `serial_out` drives that block's `serial_in` and `shift_out` drives its `shift`. A bit-period divider lets each bit be held for several clocks.

## Interface

Parameters:

- `DATA_WIDTH`, 8: word width in bits; must be ≥ 2.
- `CLKS_PER_BIT`, 1: clock cycles each bit is held on `serial_out`; must be ≥ 1.
- `LSB_FIRST`, 0: 0 sends MSB first; 1 sends LSB first.

Ports:

- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it (low) forces all state to reset values immediately. Release is synchronous to `clk`.
- `in_data` input DATA_WIDTH: parallel word, sampled only on an accept edge.
- `in_valid` input 1: the upstream side has a word on `in_data`.
- `in_ready` output 1: the block can accept a word; registered.
- `serial_out` output 1: current serial bit; registered.
- `shift_out` output 1: one-cycle strobe, high in the last cycle of each bit period; registered.
- `busy` output 1: a frame is in progress; registered.
- `frame_done` output 1: one-cycle pulse after the final bit period; registered.

## Operation

- FSM states: IDLE and SHIFT.
- Reset values: state IDLE, `in_ready`=1, `serial_out`=0, `shift_out`=0, `busy`=0, `frame_done`=0. Internal shift register, bit counter and divider counter are all 0.
- IDLE: `in_ready`=1. An accept occurs on a rising edge where `in_valid`=1 and `in_ready`=1. At that edge:
  - load `in_data` into the shift register;
  - clear the bit counter and divider counter;
  - move to SHIFT;
  - set `busy`=1 and `in_ready`=0;
  - set `serial_out` to the first bit: `in_data[DATA_WIDTH-1]`, or `in_data[0]` when LSB_FIRST=1.
- SHIFT, bit period:
  - The divider counts 0..CLKS_PER_BIT-1 (width $clog2(CLKS_PER_BIT), minimum 1).
  - `shift_out`=1 during the cycle in which the divider equals CLKS_PER_BIT-1; otherwise 0.
  - At the end of that cycle the register shifts by one toward the output end, the bit counter increments, and `serial_out` presents the next bit.
- SHIFT, frame end:
  - The bit counter has width $clog2(DATA_WIDTH). It wraps at no point, because the frame ends at count DATA_WIDTH-1.
  - At the end of the strobe cycle for bit DATA_WIDTH-1: return to IDLE, set `in_ready`=1, `busy`=0, `serial_out`=0, and pulse `frame_done`=1 for exactly one cycle.
- `in_valid` while busy is ignored. `in_data` changes during SHIFT do not affect the frame in flight.
- `in_valid` held high continuously gives back-to-back frames with the gap defined under Timing.
- Reset asserted mid-frame: the frame is abandoned with no `frame_done` and no further `shift_out`; all outputs go to reset values asynchronously.

## Timing

In this section E0 is the accept edge, W = DATA_WIDTH and C = CLKS_PER_BIT.

- Latency: the first bit is valid on `serial_out` in the cycle after E0.
- Bit k (0-based, in send order) is driven from edge E0+k·C to edge E0+(k+1)·C.
- `shift_out` is high in the cycle following edge E0+(k+1)·C−1. `serial_out` and `shift_out` update on the same edge, so downstream sampling at the next edge sees a stable bit.
- Edge E0+W·C: IDLE; `frame_done`=1 for that cycle; `in_ready`=1.
- Earliest next accept is edge E0+W·C+1. Frame period is W·C+1 cycles, and the idle gap has `serial_out`=0 and `shift_out`=0.
- With C=1, `shift_out` is high for W consecutive cycles.
- `frame_done` and `in_ready` rise together. An accept on the edge where `frame_done` is high is legal and starts the next frame.

## Test plan

- Reset: hold `reset` low with arbitrary inputs → `in_ready`=1 and `serial_out`, `shift_out`, `busy`, `frame_done` all 0. Assert `reset` asynchronously between clock edges → outputs change without waiting for a clock.
- Single frame, defaults, `in_data`=0xA5 → `serial_out` is 1,0,1,0,0,1,0,1 over cycles 1–8 after accept; `shift_out` is high in cycles 1–8; `frame_done` is high in cycle 9 only. A SIPO model clocked by these outputs captures 0xA5.
- CLKS_PER_BIT=4, `in_data`=0x3C → each bit is held 4 cycles, `shift_out` is high only in the 4th, there are 8 strobes total, and `frame_done` fires at cycle 33.
- Back-to-back frames: `in_valid` held high with 0x81 then 0x7E → exactly one idle cycle between frames with `serial_out`=0 and `shift_out`=0. `in_data` toggled to 0xFF during frame 1 does not corrupt it. Both words are received intact.
- Reset mid-frame: assert `reset` after the 3rd strobe of 0xF0 → no `frame_done` and no further strobes. After release, frame 0x55 serializes correctly as 0,1,0,1,0,1,0,1.
- LSB_FIRST=1, `in_data`=0x01 → `serial_out` is 1 followed by seven 0s.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out serializer with valid/ready word intake.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   in_data    : parallel word, sampled on the accept edge
//   in_valid   : upstream offers a word
//   in_ready   : block can accept a word (registered)
//   serial_out : current serial bit (registered)
//   shift_out  : strobe in the last cycle of each bit period (registered)
//   busy       : a frame is in progress (registered)
//   frame_done : one-cycle pulse after the final bit period (registered)
module piso_serializer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          LSB_FIRST    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  serial_out,
  output logic                  shift_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  // With one clock per bit every SHIFT cycle is a strobe cycle.
  localparam logic STROBE_AT_START = (CLKS_PER_BIT == 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;

  logic                  first_bit_c;
  logic                  next_bit_c;
  logic [DATA_WIDTH-1:0] sreg_shifted_c;
  logic [DIV_W-1:0]      div_inc_c;

  // Output end of the register depends on bit order.
  always_comb begin
    first_bit_c    = LSB_FIRST ? in_data[0] : in_data[DATA_WIDTH-1];
    next_bit_c     = LSB_FIRST ? sreg[1] : sreg[DATA_WIDTH-2];
    sreg_shifted_c = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
    div_inc_c      = div_cnt + DIV_W'(1);
  end

  // Control FSM; shift_out is precomputed one edge ahead so it is high
  // exactly when the divider sits at its last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      in_ready   <= 1'b1;
      serial_out <= 1'b0;
      shift_out  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg       <= in_data;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            state      <= SHIFT;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
            serial_out <= first_bit_c;
            shift_out  <= STROBE_AT_START;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              in_ready   <= 1'b1;
              busy       <= 1'b0;
              serial_out <= 1'b0;
              shift_out  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              sreg       <= sreg_shifted_c;
              bit_cnt    <= bit_cnt + BIT_W'(1);
              serial_out <= next_bit_c;
              shift_out  <= STROBE_AT_START;
            end
          end else begin
            div_cnt   <= div_inc_c;
            shift_out <= (div_inc_c == DIV_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three serializer instances (C=1 MSB-first, C=4 MSB-first,
// C=2 LSB-first) driven by directed and random frames, checked against a
// per-cycle stream model and a SIPO capture model.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       in_valid [3];
  logic [7:0] in_data  [3];
  logic       rdy_v    [3];
  logic       so_v     [3];
  logic       sh_v     [3];
  logic       busy_v   [3];
  logic       fd_v     [3];

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(rdy_v[0]), .serial_out(so_v[0]), .shift_out(sh_v[0]),
    .busy(busy_v[0]), .frame_done(fd_v[0]));

  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(rdy_v[1]), .serial_out(so_v[1]), .shift_out(sh_v[1]),
    .busy(busy_v[1]), .frame_done(fd_v[1]));

  piso_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .LSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(rdy_v[2]), .serial_out(so_v[2]), .shift_out(sh_v[2]),
    .busy(busy_v[2]), .frame_done(fd_v[2]));

  function automatic int cpb(input int d);
    case (d)
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit lsbf(input int d);
    return (d == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle-state expectations for one instance.
  task automatic chk_idle(input int d, input string tag);
    chk($sformatf("%s rdy d%0d", tag, d),  32'(rdy_v[d]),  32'd1);
    chk($sformatf("%s so d%0d", tag, d),   32'(so_v[d]),   32'd0);
    chk($sformatf("%s sh d%0d", tag, d),   32'(sh_v[d]),   32'd0);
    chk($sformatf("%s busy d%0d", tag, d), 32'(busy_v[d]), 32'd0);
    chk($sformatf("%s fd d%0d", tag, d),   32'(fd_v[d]),   32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk_idle(d, "idle");
    end
  endtask

  // Sends one word starting from a negedge in an accept-capable cycle and
  // returns at the negedge of the frame_done cycle.
  task automatic run_frame(input int d, input logic [7:0] data, input bit hold, input bit corrupt);
    int         c;
    int         total;
    int         k;
    int         strobes;
    bit         lsb;
    logic       exp_bit;
    logic       exp_sh;
    logic [7:0] cap;
    c       = cpb(d);
    lsb     = lsbf(d);
    total   = 8 * c;
    strobes = 0;
    cap     = 8'h00;
    chk($sformatf("ready_pre d%0d", d), 32'(rdy_v[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid[d] = 1'b0;
    in_data[d] = corrupt ? 8'hFF : 8'($urandom);
    for (int t = 1; t <= total; t++) begin
      if (t > 1) @(negedge clk);
      k       = (t - 1) / c;
      exp_bit = lsb ? data[k] : data[7-k];
      exp_sh  = (((t - 1) % c) == (c - 1));
      chk($sformatf("serial d%0d t%0d", d, t), 32'(so_v[d]),   32'(exp_bit));
      chk($sformatf("shift d%0d t%0d", d, t),  32'(sh_v[d]),   32'(exp_sh));
      chk($sformatf("busy d%0d t%0d", d, t),   32'(busy_v[d]), 32'd1);
      chk($sformatf("ready d%0d t%0d", d, t),  32'(rdy_v[d]),  32'd0);
      chk($sformatf("done d%0d t%0d", d, t),   32'(fd_v[d]),   32'd0);
      if (sh_v[d] === 1'b1) begin
        strobes++;
        cap = lsb ? {so_v[d], cap[7:1]} : {cap[6:0], so_v[d]};
      end
    end
    @(negedge clk);
    chk($sformatf("end_done d%0d", d),  32'(fd_v[d]),   32'd1);
    chk($sformatf("end_ready d%0d", d), 32'(rdy_v[d]),  32'd1);
    chk($sformatf("end_busy d%0d", d),  32'(busy_v[d]), 32'd0);
    chk($sformatf("end_so d%0d", d),    32'(so_v[d]),   32'd0);
    chk($sformatf("end_sh d%0d", d),    32'(sh_v[d]),   32'd0);
    chk($sformatf("strobes d%0d", d),   32'(strobes),   32'd8);
    chk($sformatf("sipo d%0d", d),      32'(cap),       32'(data));
  endtask

  initial begin
    int         d;
    logic [7:0] w;
    n_tests = 0;
    n_fail  = 0;

    // Reset held with arbitrary inputs.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'($urandom);
      in_data[i]  = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    reset = 1'b1;
    idle_cycles(2);

    // Directed frames.
    run_frame(0, 8'hA5, 1'b0, 1'b0);
    idle_cycles(1);
    run_frame(1, 8'h3C, 1'b0, 1'b0);
    idle_cycles(1);
    run_frame(2, 8'h01, 1'b0, 1'b0);
    idle_cycles(1);

    // Back-to-back with valid held high and in_data disturbed mid-frame.
    run_frame(0, 8'h81, 1'b1, 1'b1);
    run_frame(0, 8'h7E, 1'b0, 1'b0);
    idle_cycles(1);

    // Reset asserted mid-frame after the third strobe.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_sh3", 32'(sh_v[0]), 32'd1);
    @(posedge clk);
    #2;
    chk("mid_busy_pre", 32'(busy_v[0]), 32'd1);
    chk("mid_sh_pre",   32'(sh_v[0]),   32'd1);
    reset = 1'b0;
    #1;
    chk_idle(0, "async_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_sh", 32'(sh_v[0]), 32'd0);
      chk("rst_hold_fd", 32'(fd_v[0]), 32'd0);
    end
    reset = 1'b1;
    idle_cycles(3);
    run_frame(0, 8'h55, 1'b0, 1'b0);
    idle_cycles(1);

    // Random frames on random instances, optional gaps.
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(2, 0));
      w = 8'($urandom);
      run_frame(d, w, 1'b0, 1'b0);
      if ($urandom_range(1, 0) == 1) idle_cycles(int'($urandom_range(2, 1)));
    end
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
